jam_monitor: RTL and testbench
==============================

# jam_monitor

Observer for the single-lane traffic strip. It consumes the per-tick occupancy frame that drives the 20-LED road display, where each bit is one cell and set means a car is present. For each frame it serially scans the cells and reports the longest contiguous car run, the occupancy and the cars exiting the road. It raises a sticky jam flag, together with the onset frame index, when the jamming transition persists. It sits downstream of the simulation core, between the core and the status/debug LEDs.

## Interface
- `DIM`, 20: road cells per frame.
- `JAM_LEN`, 4: run length, in cells, that counts as a jammed frame.
- `HOLD`, 2: consecutive jammed frames needed to assert jam (≥1).
- `CNT_W`, 11: width of frame, exit and onset counters.
- `i_clk` in 1: single clock; everything on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: frame present on `i_cells`.
- `i_cells` in DIM: occupancy; bit0 = cell 1 (entry), bit DIM-1 = cell DIM (exit).
- `o_ready` out 1: block accepts a frame this cycle.
- `o_done` out 1: one-cycle pulse; result outputs updated.
- `o_max_run` out $clog2(DIM+1): longest run of set bits in last frame.
- `o_occ` out $clog2(DIM+1): set-bit count of last frame.
- `o_exits` out CNT_W: saturating count of exit events.
- `o_frames` out CNT_W: saturating count of frames accepted.
- `o_jam` out 1: sticky jam flag.
- `o_jam_frame` out CNT_W: frame index (0-based) of first frame of the onset streak.

## Operation
- Frame accepted when `i_valid && o_ready`; `i_cells` captured into a shift register; `o_frames` increments, saturating at 2^CNT_W−1. The frame index used for onset is the pre-increment value.
- FSM states and transitions:
  - IDLE: `o_ready`=1. Moves to SCAN on accept.
  - SCAN: lasts exactly DIM cycles and examines one cell per cycle, bit0 first. Current run resets on a 0 and increments on a 1; max-run = max(max-run, run); occ increments on a 1. Moves to EVAL.
  - EVAL: lasts 1 cycle and commits results:
    - Exit event: previous frame's bit DIM-1 = 1 and current bit DIM-1 = 0; `o_exits` +1, saturating. The previous-frame bit is 0 after reset.
    - Streak: if max-run ≥ JAM_LEN then streak +1 (saturating at HOLD) and the streak-start index is recorded when streak goes 0→1; otherwise streak = 0.
    - Jam: if streak reaches HOLD and `o_jam`=0, set `o_jam` and load `o_jam_frame` with the streak-start index.
    - Moves to IDLE.
- `o_jam`/`o_jam_frame` stay held until reset; later streaks are ignored.
- An all-zero frame gives max_run=0, occ=0. An all-ones frame gives max_run=DIM.
- `i_valid` while `o_ready`=0 is ignored. There is no buffering; the producer holds or drops the frame.

## Timing
- Accept in cycle T. SCAN occupies T+1..T+DIM. EVAL is T+DIM+1. In T+DIM+2, `o_done`=1, `o_ready`=1 and the results are visible. Latency is DIM+2 cycles; one frame per DIM+2 cycles max.
- A new frame may be accepted in the same cycle as `o_done`.
- Result outputs change only on the `o_done` cycle and are stable otherwise.
- Reset, while `i_rst` is high: state IDLE; `o_ready`=0; all other outputs 0; streak, previous-exit bit and shift register cleared. `o_ready`=1 the first cycle after `i_rst` falls.
- Reset mid-SCAN/EVAL discards the frame; no `o_done` is produced for it.
- Counter saturation: `o_frames` stuck at max keeps the same index for later onsets; this is accepted.

## Structure
- Package `jam_pkg`: FSM state enum (IDLE, SCAN, EVAL), default DIM/JAM_LEN/HOLD/CNT_W constants, run-width localparam helper.
- Sub-module `run_length_scanner`: shift register, cell index counter, run/max/occ accumulators, with a start/busy/finish interface. The top holds the FSM, exit detection, streak and jam logic.

## Test plan
- Reset release, then frame 20'h0000F → `o_done` at T+22; max_run=4, occ=4, exits=0, frames=1, jam=0.
- Frames 0x0000F, 0x000F0 (HOLD=2) → after 2nd `o_done`: jam=1, jam_frame=0; then 0x00000 → jam stays 1.
- Frame 0x80000 then 0x00000 → exits=1; 0x80000, 0x80000 → exits unchanged.
- Frame 0x55555 → max_run=1, occ=10. Frame 0xFFFFF → max_run=20, occ=20.
- Frames 0x0000F, 0x00000, 0x0000F, 0x0000F → jam=1, jam_frame=2.
- `i_rst` pulse at T+5 during SCAN → no `o_done`, all outputs 0. `i_valid` held high during busy → exactly one accept per DIM+2 cycles.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared types and defaults for the jam monitor slice.
// Contents: FSM state enum, default geometry constants, run-width helper.
package jam_pkg;

    localparam int unsigned DEF_DIM     = 20;
    localparam int unsigned DEF_JAM_LEN = 4;
    localparam int unsigned DEF_HOLD    = 2;
    localparam int unsigned DEF_CNT_W   = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EVAL = 2'd2
    } state_e;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int unsigned run_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/jam_monitor_if.sv
// Frame/result bus between the traffic core, the jam monitor and the status LEDs.
// master: frame producer (drives i_valid/i_cells, observes results).
// slave : jam_monitor (accepts frames, drives ready/done/results).
interface jam_monitor_if
    import jam_pkg::*;
#(
    parameter int unsigned DIM   = DEF_DIM,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    localparam int unsigned RUN_W = run_w(DIM);

    logic             i_valid;
    logic [DIM-1:0]   i_cells;
    logic             o_ready;
    logic             o_done;
    logic [RUN_W-1:0] o_max_run;
    logic [RUN_W-1:0] o_occ;
    logic [CNT_W-1:0] o_exits;
    logic [CNT_W-1:0] o_frames;
    logic             o_jam;
    logic [CNT_W-1:0] o_jam_frame;

    modport master (
        output i_valid, i_cells,
        input  o_ready, o_done, o_max_run, o_occ, o_exits, o_frames, o_jam, o_jam_frame
    );

    modport slave (
        input  i_valid, i_cells,
        output o_ready, o_done, o_max_run, o_occ, o_exits, o_frames, o_jam, o_jam_frame
    );

endinterface

// File: rtl/run_length_scanner.sv
// Serial scanner: walks one cell per cycle (bit0 first) and accumulates the
// longest run of set cells and the set-cell count.
// Ports: i_clk, i_rst (sync, active-high), i_start/i_cells load a frame,
// o_busy while scanning, o_last_c high in the cycle the final cell is consumed,
// o_max_run/o_occ hold the accumulators (final once o_busy drops).
module run_length_scanner #(
    parameter int unsigned DIM   = 20,
    parameter int unsigned RUN_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DIM-1:0]   i_cells,
    output logic             o_busy,
    output logic             o_last_c,
    output logic [RUN_W-1:0] o_max_run,
    output logic [RUN_W-1:0] o_occ
);
    localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    logic [DIM-1:0]   shreg_q;
    logic [IDX_W-1:0] idx_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] max_q;
    logic [RUN_W-1:0] occ_q;
    logic             busy_q;
    logic [RUN_W-1:0] run_n;

    // Run length including the cell being examined this cycle.
    always_comb begin
        run_n = '0;
        if (shreg_q[0]) begin
            run_n = run_q + RUN_W'(1);
        end
    end

    // Load on start, then consume one cell per cycle until the last index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
            run_q   <= '0;
            max_q   <= '0;
            occ_q   <= '0;
            busy_q  <= 1'b0;
        end else if (i_start) begin
            shreg_q <= i_cells;
            idx_q   <= '0;
            run_q   <= '0;
            max_q   <= '0;
            occ_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            shreg_q <= shreg_q >> 1;
            run_q   <= run_n;
            max_q   <= (run_n > max_q) ? run_n : max_q;
            occ_q   <= occ_q + RUN_W'(shreg_q[0]);
            if (idx_q == IDX_W'(DIM - 1)) begin
                busy_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign o_busy    = busy_q;
    assign o_last_c  = busy_q && (idx_q == IDX_W'(DIM - 1));
    assign o_max_run = max_q;
    assign o_occ     = occ_q;

endmodule

// File: rtl/jam_monitor.sv
// Per-frame traffic observer: accepts an occupancy frame, scans it serially,
// then commits longest run, occupancy, exit count, frame count and a sticky
// jam flag with the index of the first frame of the jamming streak.
// Ports: i_clk, i_rst (sync, active-high), bus (jam_monitor_if.slave).
module jam_monitor
    import jam_pkg::*;
#(
    parameter int unsigned DIM     = DEF_DIM,
    parameter int unsigned JAM_LEN = DEF_JAM_LEN,
    parameter int unsigned HOLD    = DEF_HOLD,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    jam_monitor_if.slave  bus
);
    localparam int unsigned RUN_W    = run_w(DIM);
    localparam int unsigned STREAK_W = run_w(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic [RUN_W-1:0]    max_run_q, max_run_d;
    logic [RUN_W-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0]    exits_q, exits_d;
    logic [CNT_W-1:0]    frames_q, frames_d;
    logic                jam_q, jam_d;
    logic [CNT_W-1:0]    jam_frame_q, jam_frame_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]    frame_idx_q, frame_idx_d;
    logic [CNT_W-1:0]    start_idx_q, start_idx_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                prev_exit_q, prev_exit_d;
    logic                cur_exit_q, cur_exit_d;

    logic                scan_start_c;
    logic                scan_busy;
    logic                scan_last_c;
    logic [RUN_W-1:0]    scan_max;
    logic [RUN_W-1:0]    scan_occ;

    run_length_scanner #(
        .DIM   (DIM),
        .RUN_W (RUN_W)
    ) u_scan (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (scan_start_c),
        .i_cells   (bus.i_cells),
        .o_busy    (scan_busy),
        .o_last_c  (scan_last_c),
        .o_max_run (scan_max),
        .o_occ     (scan_occ)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        max_run_d    = max_run_q;
        occ_d        = occ_q;
        exits_d      = exits_q;
        frames_d     = frames_q;
        jam_d        = jam_q;
        jam_frame_d  = jam_frame_q;
        frame_cnt_d  = frame_cnt_q;
        frame_idx_d  = frame_idx_q;
        start_idx_d  = start_idx_q;
        streak_d     = streak_q;
        prev_exit_d  = prev_exit_q;
        cur_exit_d   = cur_exit_q;
        scan_start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_valid && ready_q && !scan_busy) begin
                    scan_start_c = 1'b1;
                    state_d      = SCAN;
                    frame_idx_d  = frame_cnt_q;
                    cur_exit_d   = bus.i_cells[DIM-1];
                    if (frame_cnt_q != CNT_MAX) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            SCAN: begin
                if (scan_last_c) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                max_run_d   = scan_max;
                occ_d       = scan_occ;
                frames_d    = frame_cnt_q;
                prev_exit_d = cur_exit_q;
                // A car leaving the last cell shows up as 1 -> 0 on the exit bit.
                if (prev_exit_q && !cur_exit_q && (exits_q != CNT_MAX)) begin
                    exits_d = exits_q + CNT_W'(1);
                end
                if (scan_max >= RUN_W'(JAM_LEN)) begin
                    if (streak_q == '0) begin
                        start_idx_d = frame_idx_q;
                    end
                    if (streak_q != STREAK_W'(HOLD)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else begin
                    streak_d = '0;
                end
                // With HOLD=1 the streak starts and completes on this frame.
                if ((streak_d == STREAK_W'(HOLD)) && !jam_q) begin
                    jam_d       = 1'b1;
                    jam_frame_d = (streak_q == '0) ? frame_idx_q : start_idx_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            max_run_q   <= '0;
            occ_q       <= '0;
            exits_q     <= '0;
            frames_q    <= '0;
            jam_q       <= 1'b0;
            jam_frame_q <= '0;
            frame_cnt_q <= '0;
            frame_idx_q <= '0;
            start_idx_q <= '0;
            streak_q    <= '0;
            prev_exit_q <= 1'b0;
            cur_exit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            max_run_q   <= max_run_d;
            occ_q       <= occ_d;
            exits_q     <= exits_d;
            frames_q    <= frames_d;
            jam_q       <= jam_d;
            jam_frame_q <= jam_frame_d;
            frame_cnt_q <= frame_cnt_d;
            frame_idx_q <= frame_idx_d;
            start_idx_q <= start_idx_d;
            streak_q    <= streak_d;
            prev_exit_q <= prev_exit_d;
            cur_exit_q  <= cur_exit_d;
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_done      = done_q;
    assign bus.o_max_run   = max_run_q;
    assign bus.o_occ       = occ_q;
    assign bus.o_exits     = exits_q;
    assign bus.o_frames    = frames_q;
    assign bus.o_jam       = jam_q;
    assign bus.o_jam_frame = jam_frame_q;

endmodule

// File: tb/tb_jam_monitor.sv
// Scoreboard bench for jam_monitor: the driver pushes hand-computed results,
// a negedge monitor pops and compares them whenever o_done pulses.
module tb_jam_monitor;

    localparam int unsigned DIM = 20;
    localparam int unsigned LAT = DIM + 2;

    typedef struct {
        int max_run;
        int occ;
        int exits;
        int frames;
        int jam;
        int jam_frame;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_fail;
    exp_t sb_q[$];

    jam_monitor_if #(.DIM(DIM), .CNT_W(11)) bus ();

    jam_monitor #(
        .DIM     (DIM),
        .JAM_LEN (4),
        .HOLD    (2),
        .CNT_W   (11)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result checker: every o_done must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.o_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("max_run", int'(bus.o_max_run), e.max_run);
                chk("occ", int'(bus.o_occ), e.occ);
                chk("exits", int'(bus.o_exits), e.exits);
                chk("frames", int'(bus.o_frames), e.frames);
                chk("jam", int'(bus.o_jam), e.jam);
                chk("jam_frame", int'(bus.o_jam_frame), e.jam_frame);
                chk("ready_on_done", int'(bus.o_ready), 1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(bus.o_ready), 0);
        chk({tag, "_done"}, int'(bus.o_done), 0);
        chk({tag, "_max_run"}, int'(bus.o_max_run), 0);
        chk({tag, "_occ"}, int'(bus.o_occ), 0);
        chk({tag, "_exits"}, int'(bus.o_exits), 0);
        chk({tag, "_frames"}, int'(bus.o_frames), 0);
        chk({tag, "_jam"}, int'(bus.o_jam), 0);
        chk({tag, "_jam_frame"}, int'(bus.o_jam_frame), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(bus.o_ready), 1);
    endtask

    task automatic send(input logic [DIM-1:0] cells, input int mx, input int oc,
                        input int ex, input int fr, input int jm, input int jf);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_cells = cells;
        while (!bus.o_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.o_ready) begin
            chk("accept_timeout", 0, 1);
            bus.i_valid = 1'b0;
            return;
        end
        e.max_run = mx; e.occ = oc; e.exits = ex; e.frames = fr;
        e.jam = jm; e.jam_frame = jf; e.cyc = cyc + LAT;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        int accepts;
        int last_acc;
        int guard;
        int t_acc;
        exp_t e;

        n_vec = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_cells = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_init", int'(bus.o_ready), 1);

        // Basic run, jam onset after two long-run frames, jam stays sticky.
        send(20'h0000F, 4, 4, 0, 1, 0, 0);
        send(20'h000F0, 4, 4, 0, 2, 1, 0);
        send(20'h00000, 0, 0, 0, 3, 1, 0);
        // Exit detection on the last cell.
        send(20'h80000, 1, 1, 0, 4, 1, 0);
        send(20'h00000, 0, 0, 1, 5, 1, 0);
        send(20'h80000, 1, 1, 1, 6, 1, 0);
        send(20'h80000, 1, 1, 1, 7, 1, 0);
        // Alternating cells (bit19 clear -> exit) and full road.
        send(20'h55555, 1, 10, 2, 8, 1, 0);
        send(20'hFFFFF, 20, 20, 2, 9, 1, 0);
        drain();

        // Onset index comes from the first frame of the completed streak.
        apply_reset();
        send(20'h0000F, 4, 4, 0, 1, 0, 0);
        send(20'h00000, 0, 0, 0, 2, 0, 0);
        send(20'h0000F, 4, 4, 0, 3, 0, 0);
        send(20'h0000F, 4, 4, 0, 4, 1, 2);
        drain();

        // Valid held high: one accept per DIM+2 cycles.
        @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_cells = 20'h0000F;
        accepts = 0;
        last_acc = 0;
        guard = 0;
        while (accepts < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (bus.o_ready) begin
                if (accepts > 0) chk("accept_spacing", cyc - last_acc, LAT);
                last_acc = cyc;
                e.max_run = 4; e.occ = 4; e.exits = 0; e.frames = 5 + accepts;
                e.jam = 1; e.jam_frame = 2; e.cyc = cyc + LAT;
                sb_q.push_back(e);
                accepts++;
            end
        end
        chk("held_valid_accepts", accepts, 3);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        drain();

        // Reset during SCAN discards the frame: no o_done, outputs cleared.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_cells = 20'h0000F;
        chk("ready_before_abort", int'(bus.o_ready), 1);
        t_acc = cyc;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        while (cyc < t_acc + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", int'(bus.o_ready), 1);
        repeat (40) @(negedge clk);
        chk("abort_frames_zero", int'(bus.o_frames), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
